// File: rtl/servant_pkg.sv
// Shared definitions for the servant SoC: memory map constants, RAM decode helper
// and the RAM responder request-state encoding.
package servant_pkg;

  localparam logic [31:0] RAM_BASE       = 32'h0000_8000;
  localparam int          RAM_SIZE_BYTES = 8192;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ram_state_e;

  // Also used by the arbiter, so both sides agree on what lands in RAM.
  function automatic logic is_ram_adr(input logic [31:0] adr);
    return (adr[31:16] == 16'h0000) && (adr[15:13] == 3'b100);
  endfunction

endpackage

// File: rtl/servant_boot_packer.sv
// Packs the UART loader byte stream little-endian into 32-bit words and
// produces one word-write strobe per completed word, starting from word 0.
module servant_boot_packer
  import servant_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_boot_mode,
  input  logic [7:0]    i_ld_dat,
  input  logic          i_ld_vld,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_idx,
  output logic [31:0]   o_wr_dat,
  output logic [AW:0]   o_words
);

  localparam logic [AW:0] WORDS_MAX = (AW+1)'(DEPTH);

  logic [1:0]  cnt_p1;
  logic [23:0] asm_p1;
  logic [AW:0] words_p1;
  logic        boot_p1;

  logic [AW:0] words_base;
  logic        accept;
  logic        full;

  // A rising boot_mode restarts the pointer in the same edge, so a byte that
  // arrives in that very cycle still lands in word 0.
  always_comb begin
    words_base = (i_boot_mode && !boot_p1) ? '0 : words_p1;
    accept     = i_boot_mode && i_ld_vld && (words_base != WORDS_MAX);
    full       = accept && (cnt_p1 == 2'd3);
    o_wr_stb   = full;
    o_wr_idx   = words_base[AW-1:0];
    o_wr_dat   = {i_ld_dat, asm_p1};
  end

  // Stage p1: byte counter, assembly register and committed-word pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_p1   <= 2'd0;
      asm_p1   <= 24'd0;
      words_p1 <= '0;
      boot_p1  <= 1'b0;
    end else begin
      boot_p1 <= i_boot_mode;
      if (!i_boot_mode) begin
        cnt_p1 <= 2'd0;
        asm_p1 <= 24'd0;
      end else begin
        words_p1 <= words_base + {{AW{1'b0}}, full};
        if (accept) begin
          if (full) begin
            cnt_p1 <= 2'd0;
            asm_p1 <= 24'd0;
          end else begin
            cnt_p1 <= cnt_p1 + 2'd1;
            case (cnt_p1)
              2'd0:    asm_p1[7:0]   <= i_ld_dat;
              2'd1:    asm_p1[15:8]  <= i_ld_dat;
              default: asm_p1[23:16] <= i_ld_dat;
            endcase
          end
        end
      end
    end
  end

  assign o_words = words_p1;

endmodule

// File: rtl/servant_ram_responder.sv
// Wishbone-classic responder for the on-chip RAM: one-cycle ack, byte-lane writes,
// registered reads, plus a boot-mode loader path into the same write port.
module servant_ram_responder
  import servant_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int AW      = $clog2(DEPTH),
  parameter     MEMFILE = ""
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_boot_mode,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  input  logic [7:0]    i_ld_dat,
  input  logic          i_ld_vld,
  output logic [AW:0]   o_ld_words
);

  // Preloading is left to the integration flow; the name is kept for compatibility.
  localparam bit unused_memfile = (MEMFILE != "");

  // Upstream decode owns the high address bits; byte offset is covered by sel.
  logic unused_adr;
  assign unused_adr = &{1'b0, i_wb_adr[31:AW+2], i_wb_adr[1:0], unused_memfile};

  ram_state_e      state_p1, state_nxt;
  logic            take;
  logic [AW-1:0]   wb_idx;
  logic [31:0]     rdt_p1;

  logic            ld_stb;
  logic [AW-1:0]   ld_idx;
  logic [31:0]     ld_wdat;

  logic [3:0]      mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdat;
  logic [31:0]     mem [DEPTH];

  assign wb_idx = i_wb_adr[AW+1:2];

  always_comb begin
    state_nxt = state_p1;
    take      = 1'b0;
    case (state_p1)
      ST_IDLE: begin
        if (i_wb_cyc && !i_boot_mode) begin
          take      = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: request state and read data register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p1 <= ST_IDLE;
      rdt_p1   <= 32'd0;
    end else begin
      state_p1 <= state_nxt;
      if (take && !i_wb_we)
        rdt_p1 <= mem[wb_idx];
    end
  end

  assign o_wb_ack = (state_p1 == ST_ACK);
  assign o_wb_rdt = rdt_p1;

  servant_boot_packer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_boot_mode (i_boot_mode),
    .i_ld_dat    (i_ld_dat),
    .i_ld_vld    (i_ld_vld),
    .o_wr_stb    (ld_stb),
    .o_wr_idx    (ld_idx),
    .o_wr_dat    (ld_wdat),
    .o_words     (o_ld_words)
  );

  // Loader and Wishbone writes never coincide: requests are only taken outside boot mode.
  always_comb begin
    mem_we   = 4'b0000;
    mem_widx = wb_idx;
    mem_wdat = i_wb_dat;
    if (ld_stb) begin
      mem_we   = 4'b1111;
      mem_widx = ld_idx;
      mem_wdat = ld_wdat;
    end else if (take && i_wb_we) begin
      mem_we   = i_wb_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b])
        mem[mem_widx][8*b +: 8] <= mem_wdat[8*b +: 8];
    end
  end

endmodule
